// File: rtl/tdm_demux_rx_pkg.sv
// Shared definitions for the TDM demux receiver: FSM states, default geometry, slot-index sizing.
// Slot-index sizing depends on TDM_DEMUX_PARITY_EN (adds one parity slot per frame).
package tdm_demux_rx_pkg;

  localparam int unsigned TDM_CHANNELS = 4;
  localparam int unsigned TDM_WIDTH    = 1;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

  // Slots per frame: data slots plus the optional trailing parity slot.
  function automatic int unsigned tdm_slots(input int unsigned channels);
`ifdef TDM_DEMUX_PARITY_EN
    return channels + 1;
`else
    return channels;
`endif
  endfunction

  function automatic int unsigned tdm_sel_w(input int unsigned channels);
    return $clog2(tdm_slots(channels));
  endfunction

endpackage

// File: rtl/tdm_demux_rx_slot_counter.sv
// Slot index counter: clear, load-to-1 on frame sync, en-qualified increment wrapping after LAST.
module tdm_slot_counter #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned LAST  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  output logic [SEL_W-1:0] cnt,
  output logic             tc
);

  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_d;

  assign tc  = (cnt_q == SEL_W'(LAST));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = SEL_W'(1);
    else if (inc)  cnt_d = tc ? '0 : cnt_q + SEL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM 4:1 link receiver: frame-sync hunt, slot tracking, shadow assembly, atomic publish to dout.
// Optional trailing parity slot enabled by TDM_DEMUX_PARITY_EN.
module tdm_demux_rx
  import tdm_demux_rx_pkg::*;
#(
  parameter int unsigned CHANNELS = TDM_CHANNELS,
  parameter int unsigned SEL_W    = tdm_sel_w(CHANNELS),
  parameter int unsigned WIDTH    = TDM_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      en,
  input  logic                      sync,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      frame_valid,
  output logic [SEL_W-1:0]          slot_sel,
  output logic                      sync_err,
  output logic                      parity_err
);

  tdm_state_e state_q, state_d;

  logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
  logic                      fv_q, fv_d;
  logic                      serr_q, serr_d;
  logic                      cnt_clr, cnt_load, cnt_inc, cnt_tc;
  logic [SEL_W-1:0]          cnt;

  tdm_slot_counter #(
    .SEL_W (SEL_W),
    .LAST  (tdm_slots(CHANNELS) - 1)
  ) u_slot_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .load (cnt_load),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .tc   (cnt_tc)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic             perr_q, perr_d;
  logic [WIDTH-1:0] par;

  always_comb begin
    par = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) par = par ^ shadow_q[k*WIDTH +: WIDTH];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        HUNT: if (sync) state_d = RUN;
        RUN:  if (!sync && cnt == '0) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    fv_d     = 1'b0;
    serr_d   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    perr_d   = 1'b0;
`endif
    if (en) begin
      if (sync) begin
        // Any sync restarts the frame; in RUN it is only legal when slot 0 is expected.
        serr_d                = (state_q == RUN) && (cnt != '0);
        shadow_d[0 +: WIDTH]  = din;
        cnt_load              = 1'b1;
      end else if (state_q == RUN) begin
        if (cnt == '0) begin
          serr_d  = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          for (int unsigned k = 1; k < CHANNELS; k++) begin
            if (cnt == SEL_W'(k)) shadow_d[k*WIDTH +: WIDTH] = din;
          end
          if (cnt_tc) begin
`ifdef TDM_DEMUX_PARITY_EN
            if (din == par) begin
              dout_d = shadow_q;
              fv_d   = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
`else
            dout_d = shadow_d;
            fv_d   = 1'b1;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;
  assign slot_sel    = cnt;
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Self-checking bench for tdm_demux_rx (CHANNELS=4, WIDTH=1); expected frames queued, popped on frame_valid.
module tb_tdm_demux_rx;
  import tdm_demux_rx_pkg::*;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 1;
  localparam int unsigned SW = tdm_sel_w(CH);

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic          en;
  logic          sync;
  logic [CH*W-1:0] dout;
  logic          fv;
  logic [SW-1:0] slot_sel;
  logic          serr;
  logic          perr;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned serr_seen = 0;
  int unsigned perr_seen = 0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  tdm_demux_rx #(
    .CHANNELS (CH),
    .WIDTH    (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .en          (en),
    .sync        (sync),
    .dout        (dout),
    .frame_valid (fv),
    .slot_sel    (slot_sel),
    .sync_err    (serr),
    .parity_err  (perr)
  );

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (fv === 1'b1) begin
        logic [3:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_frame_valid dout=%b required no publish", dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            n_err++;
            $display("FAIL frame_dout got=%b required=%b", dout, e);
          end
        end
      end
      if (serr === 1'b1) serr_seen++;
      if (perr === 1'b1) perr_seen++;
    end
  end

  task automatic slot(input logic d, input logic s);
    din = d; sync = s; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; sync = 1'b0; din = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [3:0] d, input int gap);
    for (int k = 0; k < 4; k++) begin
      slot(d[k], k == 0);
      if (gap > 0 && k < 3) idle(gap);
    end
`ifdef TDM_DEMUX_PARITY_EN
    if (gap > 0) idle(gap);
    slot(^d, 1'b0);
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; din = 1'b0; sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (dout !== 4'b0000) begin n_err++; $display("FAIL reset_dout got=%b required=0000", dout); end
    n_vec++; if (fv !== 1'b0) begin n_err++; $display("FAIL reset_fv got=%b required=0", fv); end
    n_vec++; if (serr !== 1'b0) begin n_err++; $display("FAIL reset_serr got=%b required=0", serr); end
    n_vec++; if (perr !== 1'b0) begin n_err++; $display("FAIL reset_perr got=%b required=0", perr); end
    n_vec++; if (slot_sel !== '0) begin n_err++; $display("FAIL reset_slot_sel got=%0d required=0", slot_sel); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_hunt;
    repeat (5) slot(1'b1, 1'b0);
    idle(1);
    n_vec++; if (slot_sel !== '0) begin n_err++; $display("FAIL hunt_slot_sel got=%0d required=0", slot_sel); end
    n_vec++; if (serr_seen !== 0) begin n_err++; $display("FAIL hunt_serr got=%0d required=0", serr_seen); end
    n_vec++; if (dout !== 4'b0000) begin n_err++; $display("FAIL hunt_dout got=%b required=0000", dout); end
  endtask

  task automatic test_single;
    exp_q.push_back(4'b0001);
    slot(1'b1, 1'b1);
    n_vec++; if (slot_sel !== SW'(1)) begin n_err++; $display("FAIL sync_slot_sel got=%0d required=1", slot_sel); end
    for (int k = 1; k < 4; k++) slot(1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    slot(1'b1, 1'b0);
`endif
    n_vec++; if (fv !== 1'b1) begin n_err++; $display("FAIL single_fv_latency got=%b required=1", fv); end
    idle(2);
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_pending got=%0d required=0", exp_q.size()); end
    n_vec++; if (dout !== 4'b0001) begin n_err++; $display("FAIL single_dout got=%b required=0001", dout); end
    n_vec++; if (slot_sel !== '0) begin n_err++; $display("FAIL single_slot_sel got=%0d required=0", slot_sel); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] pats [3];
    pats[0] = 4'b0010; pats[1] = 4'b0100; pats[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pats[i]);
      send_frame(pats[i], 0);
    end
    idle(2);
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending got=%0d required=0", exp_q.size()); end
    n_vec++; if (dout !== 4'b1000) begin n_err++; $display("FAIL b2b_dout got=%b required=1000", dout); end
    n_vec++; if (serr_seen !== 0) begin n_err++; $display("FAIL b2b_serr got=%0d required=0", serr_seen); end
  endtask

  task automatic test_en_gaps;
    exp_q.push_back(4'b0110);
    send_frame(4'b0110, 3);
    idle(2);
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL gaps_pending got=%0d required=0", exp_q.size()); end
    n_vec++; if (dout !== 4'b0110) begin n_err++; $display("FAIL gaps_dout got=%b required=0110", dout); end
    n_vec++; if (serr_seen !== 0) begin n_err++; $display("FAIL gaps_serr got=%0d required=0", serr_seen); end
  endtask

  task automatic test_early_sync;
    int unsigned base;
    base = serr_seen;
    slot(1'b1, 1'b1);
    slot(1'b1, 1'b0);
    n_vec++; if (slot_sel !== SW'(2)) begin n_err++; $display("FAIL early_slot_sel got=%0d required=2", slot_sel); end
    exp_q.push_back(4'b1100);
    slot(1'b0, 1'b1);
    n_vec++; if (serr !== 1'b1) begin n_err++; $display("FAIL early_serr_pulse got=%b required=1", serr); end
    n_vec++; if (dout !== 4'b0110) begin n_err++; $display("FAIL early_dout_held got=%b required=0110", dout); end
    slot(1'b0, 1'b0);
    slot(1'b1, 1'b0);
    slot(1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    slot(1'b0, 1'b0);
`endif
    idle(2);
    n_vec++; if (serr_seen !== base + 1) begin n_err++; $display("FAIL early_serr_count got=%0d required=%0d", serr_seen, base + 1); end
    n_vec++; if (dout !== 4'b1100) begin n_err++; $display("FAIL early_new_dout got=%b required=1100", dout); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL early_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_missing_sync;
    int unsigned base;
    base = serr_seen;
    slot(1'b1, 1'b0);
    slot(1'b1, 1'b0);
    slot(1'b0, 1'b0);
    idle(1);
    n_vec++; if (serr_seen !== base + 1) begin n_err++; $display("FAIL missing_serr_count got=%0d required=%0d", serr_seen, base + 1); end
    n_vec++; if (slot_sel !== '0) begin n_err++; $display("FAIL missing_slot_sel got=%0d required=0", slot_sel); end
    exp_q.push_back(4'b0101);
    send_frame(4'b0101, 0);
    idle(2);
    n_vec++; if (dout !== 4'b0101) begin n_err++; $display("FAIL missing_resync_dout got=%b required=0101", dout); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL missing_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_parity;
`ifdef TDM_DEMUX_PARITY_EN
    int unsigned base;
    base = perr_seen;
    slot(1'b1, 1'b1); slot(1'b1, 1'b0); slot(1'b0, 1'b0); slot(1'b1, 1'b0);
    slot(1'b0, 1'b0);
    idle(1);
    n_vec++; if (perr_seen !== base + 1) begin n_err++; $display("FAIL parity_err_count got=%0d required=%0d", perr_seen, base + 1); end
    n_vec++; if (dout !== 4'b0101) begin n_err++; $display("FAIL parity_dout_held got=%b required=0101", dout); end
    n_vec++; if (slot_sel !== '0) begin n_err++; $display("FAIL parity_slot_sel got=%0d required=0", slot_sel); end
    exp_q.push_back(4'b1011);
    slot(1'b1, 1'b1); slot(1'b1, 1'b0); slot(1'b0, 1'b0); slot(1'b1, 1'b0);
    slot(1'b1, 1'b0);
    idle(2);
    n_vec++; if (dout !== 4'b1011) begin n_err++; $display("FAIL parity_good_dout got=%b required=1011", dout); end
    n_vec++; if (perr_seen !== base + 1) begin n_err++; $display("FAIL parity_good_count got=%0d required=%0d", perr_seen, base + 1); end
`else
    n_vec++; if (perr_seen !== 0) begin n_err++; $display("FAIL parity_tied got=%0d required=0", perr_seen); end
`endif
  endtask

  task automatic test_reset_midframe;
    int unsigned base;
    exp_q.push_back(4'b1111);
    send_frame(4'b1111, 0);
    idle(1);
    n_vec++; if (dout !== 4'b1111) begin n_err++; $display("FAIL pre_reset_dout got=%b required=1111", dout); end
    slot(1'b1, 1'b1);
    slot(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (dout !== 4'b0000) begin n_err++; $display("FAIL midrst_dout got=%b required=0000", dout); end
    n_vec++; if (slot_sel !== '0) begin n_err++; $display("FAIL midrst_slot_sel got=%0d required=0", slot_sel); end
    n_vec++; if (fv !== 1'b0 || serr !== 1'b0) begin n_err++; $display("FAIL midrst_pulses got=%b%b required=00", fv, serr); end
    @(posedge clk); #1;
    rst = 1'b0;
    base = serr_seen;
    slot(1'b1, 1'b0);
    idle(1);
    n_vec++; if (serr_seen !== base) begin n_err++; $display("FAIL midrst_hunt_serr got=%0d required=%0d", serr_seen, base); end
    n_vec++; if (dout !== 4'b0000) begin n_err++; $display("FAIL midrst_hunt_dout got=%b required=0000", dout); end
  endtask

  initial begin
    test_reset();
    test_hunt();
    test_single();
    test_back_to_back();
    test_en_gaps();
    test_early_sync();
    test_missing_sync();
    test_parity();
    test_reset_midframe();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL final_pending got=%0d required=0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
